// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state codes and width helpers shared by the systolic tile engine
package systolic_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    typedef logic [1:0] state_t;
    function automatic int acc_width(input int dw, input int kmax);
        return 2 * dw + $clog2(kmax) + 4;
    endfunction
    function automatic int kw_of(input int kmax);
        return (kmax < 1) ? 1 : $clog2(kmax + 1);
    endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one MAC cell, passes a east and b south, accumulates a*b (saturating when SYSARR_SAT_EN is defined)
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
`ifdef SYSARR_SAT_EN
    ,
    output logic          sat
`endif
);
    logic [2*DW-1:0] prod;
    assign prod = a_in * b_in;
`ifdef SYSARR_SAT_EN
    logic [AW:0] sum;
    assign sum = {1'b0, acc} + {{(AW + 1 - 2 * DW){1'b0}}, prod};
`else
    logic [AW-1:0] sum;
    assign sum = acc + {{(AW - 2 * DW){1'b0}}, prod};
`endif
    // operand pass registers and accumulator; clear wins over accumulate, en low freezes the cell
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
`ifdef SYSARR_SAT_EN
            sat   <= 1'b0;
`endif
        end else begin
            if (en) begin
                a_out <= a_in;
                b_out <= b_in;
            end
`ifdef SYSARR_SAT_EN
            acc <= clr ? '0 : en ? (sum[AW] ? '1 : sum[AW-1:0]) : acc;
            sat <= clr ? 1'b0 : (sat | (en & sum[AW]));
`else
            acc <= clr ? '0 : en ? sum : acc;
`endif
        end
    end
endmodule

// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: NxN output-stationary MAC array with input skew, K sequencer and row drain; SYSARR_SAT_EN adds saturation and sat_flag
module systolic_tile_engine
    import systolic_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int KMAX = 256,
    localparam int AW  = acc_width(DW, KMAX),
    localparam int KW  = kw_of(KMAX),
    localparam int RW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            acc_clear,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N*AW-1:0] res_data,
    output logic [RW-1:0]   res_row,
    output logic            busy,
    output logic            done
`ifdef SYSARR_SAT_EN
    ,
    output logic            sat_flag
`endif
);
    localparam int FW = $clog2(2 * N);
    state_t state;
    logic [KW-1:0] k_q, k_cnt;
    logic [FW-1:0] f_cnt;
    logic [RW-1:0] row;
    logic take, en, clr;
    logic [N*DW-1:0] a_inj, b_inj;
    logic [DW-1:0] a_h [N][N+1];
    logic [DW-1:0] b_v [N+1][N];
    logic [AW-1:0] acc_w [N][N];
    logic [N-1:0] edge_unused;
    assign in_ready  = state == LOAD;
    assign take      = in_ready & in_valid;
    assign en        = state != DRAIN;
    assign clr       = (state == IDLE) & start & acc_clear;
    assign busy      = state != IDLE;
    assign res_valid = state == DRAIN;
    assign res_row   = row;
    assign done      = res_valid & res_ready & (row == RW'(N - 1));
    assign a_inj     = take ? a_vec : '0;
    assign b_inj     = take ? b_vec : '0;
`ifdef SYSARR_SAT_EN
    logic [N*N-1:0] sat_w;
    assign sat_flag = |sat_w;
`endif
    // sequencer: latch k_len, count accepted beats, fixed-length flush, then hand out rows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            k_q   <= '0;
            k_cnt <= '0;
            f_cnt <= '0;
            row   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k_q   <= k_len;
                    k_cnt <= '0;
                    f_cnt <= '0;
                    state <= (k_len == '0) ? FLUSH : LOAD;
                end
                LOAD: if (in_valid) begin
                    k_cnt <= k_cnt + KW'(1);
                    if (k_cnt + KW'(1) == k_q) state <= FLUSH;
                end
                FLUSH: begin
                    f_cnt <= f_cnt + FW'(1);
                    row   <= '0;
                    if (f_cnt == FW'(2 * N - 2)) state <= DRAIN;
                end
                default: if (res_ready) begin
                    row <= (row == RW'(N - 1)) ? '0 : row + RW'(1);
                    if (row == RW'(N - 1)) state <= IDLE;
                end
            endcase
        end
    end
    for (genvar r = 0; r < N; r++) begin : g_row
        if (r == 0) begin : g_d0
            assign a_h[0][0] = a_inj[0+:DW];
            assign b_v[0][0] = b_inj[0+:DW];
        end else begin : g_dly
            logic [DW-1:0] a_sr [r];
            logic [DW-1:0] b_sr [r];
            // lane r delay lines so row r and column r see beat k r cycles later
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < r; i++) begin
                        a_sr[i] <= '0;
                        b_sr[i] <= '0;
                    end
                end else if (en) begin
                    a_sr[0] <= a_inj[r*DW+:DW];
                    b_sr[0] <= b_inj[r*DW+:DW];
                    for (int i = 1; i < r; i++) begin
                        a_sr[i] <= a_sr[i-1];
                        b_sr[i] <= b_sr[i-1];
                    end
                end
            end
            assign a_h[r][0] = a_sr[r-1];
            assign b_v[0][r] = b_sr[r-1];
        end
        assign edge_unused[r] = ^{a_h[r][N], b_v[N][r]};
        assign res_data[r*AW+:AW] = acc_w[row][r];
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .clr   (clr),
                .a_in  (a_h[r][c]),
                .b_in  (b_v[r][c]),
                .a_out (a_h[r][c+1]),
                .b_out (b_v[r+1][c]),
                .acc   (acc_w[r][c])
`ifdef SYSARR_SAT_EN
                ,
                .sat   (sat_w[r*N+c])
`endif
            );
        end
    end
endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb_systolic_tile_engine: directed+random checks of the tile engine against a matrix-product model
module tb_systolic_tile_engine;
    localparam int N = 4, DW = 8, KMAX = 256, AW = 28, KW = 9, RW = 2;
    localparam longint AMAX = (64'd1 << AW) - 1;
    logic clk = 0, rst = 0, start = 0, acc_clear = 0, in_valid = 0, res_ready = 0;
    logic [KW-1:0] k_len = '0;
    logic [N*DW-1:0] a_vec = '0, b_vec = '0;
    logic in_ready, res_valid, busy, done;
    logic [N*AW-1:0] res_data;
    logic [RW-1:0] res_row;
`ifdef SYSARR_SAT_EN
    logic sat_flag;
`endif
    int vectors = 0, miscompares = 0, cyc = 0, ready_cnt = 0, acc_cyc = 0;
    longint mdl [N][N];
    int a_beat [KMAX][N];
    int b_beat [KMAX][N];

    systolic_tile_engine #(.N(N), .DW(DW), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .busy(busy), .done(done)
`ifdef SYSARR_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (in_ready) ready_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mdl[r][c] = 0;
    endtask

    task automatic model_mac(input int k);
        longint s;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = mdl[r][c] + longint'(a_beat[k][r]) * longint'(b_beat[k][c]);
`ifdef SYSARR_SAT_EN
                if (s > AMAX) s = AMAX;
`else
                s = s & AMAX;
`endif
                mdl[r][c] = s;
            end
    endtask

    task automatic start_pass(input int kl, input bit clr);
        @(negedge clk);
        check("idle_before_start", busy, 0);
        start = 1; acc_clear = clr; k_len = KW'(kl);
        if (clr) model_clear();
        @(negedge clk);
        start = 0; acc_clear = 0;
    endtask

    task automatic feed(input int kl, input int pct);
        int k = 0, g = 0;
        while (k < kl && g < 20000) begin
            @(negedge clk);
            g++;
            in_valid = ($urandom_range(99) < pct);
            a_vec = $urandom;
            b_vec = $urandom;
            if (in_valid)
                for (int i = 0; i < N; i++) begin
                    a_vec[i*DW+:DW] = a_beat[k][i][DW-1:0];
                    b_vec[i*DW+:DW] = b_beat[k][i][DW-1:0];
                end
            if (in_valid && in_ready) begin
                model_mac(k);
                k++;
                acc_cyc = cyc + 1;
            end
        end
        @(negedge clk);
        in_valid = 0;
        check("load_beats", k, kl);
    endtask

    task automatic drain(input int stall_row, input int stall_n, input bit chk_lat);
        int g;
        logic [N*AW-1:0] e;
        for (int r = 0; r < N; r++) begin
            g = 0;
            while (!res_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("res_valid", res_valid, 1);
            if (r == 0 && chk_lat) check("latency", cyc + 1 - acc_cyc, 2 * N);
            for (int c = 0; c < N; c++) e[c*AW+:AW] = mdl[r][c][AW-1:0];
            check("res_row", res_row, r);
            check("res_data", res_data, e);
            if (r == stall_row)
                for (int s = 0; s < stall_n; s++) begin
                    res_ready = 0;
                    @(negedge clk);
                    check("stall_data", res_data, e);
                    check("stall_row", res_row, r);
                end
            res_ready = 1;
            #1;
            check("done", done, r == N - 1);
            @(negedge clk);
            res_ready = 0;
        end
        check("idle_after_drain", busy, 0);
    endtask

    initial begin
        int rc0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_row", res_row, 0);
        check("rst_res_data", res_data, 0);
        rst = 1;

        // identity A, B[k][c]=4k+c
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = (i == k) ? 1 : 0;
                b_beat[k][i] = 4 * k + i;
            end
        start_pass(4, 1);
        feed(4, 100);
        drain(-1, 0, 1);

        // all-ones K tiling, second pass keeps sums; a start while busy must be ignored
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = 1;
                b_beat[k][i] = 1;
            end
        start_pass(4, 1);
        feed(4, 100);
        drain(-1, 0, 1);
        start_pass(4, 0);
        @(negedge clk);
        start = 1; acc_clear = 1; k_len = '0;
        @(negedge clk);
        start = 0; acc_clear = 0;
        feed(4, 100);
        drain(-1, 0, 1);

        // random operands with bubbles and result backpressure
        for (int it = 0; it < 3; it++) begin
            int kl;
            kl = $urandom_range(20, 6);
            for (int k = 0; k < kl; k++)
                for (int i = 0; i < N; i++) begin
                    a_beat[k][i] = $urandom_range(255);
                    b_beat[k][i] = $urandom_range(255);
                end
            start_pass(kl, it == 0);
            feed(kl, 50);
            drain((it == 0) ? 1 : -1, 3, 1);
        end

        // k_len=0 with clear, in_valid held high with junk throughout
        rc0 = ready_cnt;
        in_valid = 1;
        a_vec = '1;
        b_vec = '1;
        start_pass(0, 1);
        drain(-1, 0, 0);
        in_valid = 0;
        check("no_in_ready", ready_cnt - rc0, 0);

        // saturation / wrap: 17 chained passes of all-255 with k_len=256
        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = 255;
                b_beat[k][i] = 255;
            end
        for (int p = 0; p < 17; p++) begin
            start_pass(256, p == 0);
            feed(256, 100);
            drain(-1, 0, 0);
`ifdef SYSARR_SAT_EN
            if (p == 15) check("sat_flag_low", sat_flag, 0);
`endif
        end
`ifdef SYSARR_SAT_EN
        check("sat_flag_high", sat_flag, 1);
`endif

        // reset mid-LOAD, then a no-clear pass must start from zero
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < N; i++) begin
                a_beat[k][i] = $urandom_range(255);
                b_beat[k][i] = $urandom_range(255);
            end
        start_pass(5, 1);
        feed(2, 100);
        check("mid_load_busy", busy, 1);
        #2 rst = 0;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        check("arst_res_valid", res_valid, 0);
        check("arst_done", done, 0);
        check("arst_res_row", res_row, 0);
        check("arst_busy_edge", busy, 0);
        rst = 1;
        model_clear();
        start_pass(4, 0);
        feed(4, 60);
        drain(2, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
